// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side byte handshakes of the UART arbiter.
// master is the arbiter; slave is the surrounding sources and transmitter.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;

  modport master (
    input  req_data,
    input  req_valid,
    input  req_last,
    input  tx_ready,
    output req_ready,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output req_data,
    output req_valid,
    output req_last,
    output tx_ready,
    input  req_ready,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter sharing one UART transmitter.
// Grant is held until req_last or MAX_BURST bytes; data path is a pure mux.
module uart_tx_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int MAX_BURST      = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  uart_tx_arbiter_if.master                 bus,
  output logic [$clog2(NUM_REQUESTERS)-1:0] grant_id,
  output logic                              busy
);
  localparam int IDX_W = $clog2(NUM_REQUESTERS);
  localparam int CNT_W =
    (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [IDX_W:0] N_W =
    (IDX_W+1)'(NUM_REQUESTERS);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_REQUESTERS - 1);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] next_ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic             any_req;
  logic             xfer;
  logic             at_limit;
  logic             release_g;

  // Scan offsets high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    winner  = rr_ptr;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      idx = sum[IDX_W-1:0];
      if (bus.req_valid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  assign xfer = (state == LOCKED) &&
                bus.tx_valid && bus.tx_ready;
  assign at_limit = (MAX_BURST != 0) &&
                    (burst_cnt == LIMIT);
  assign release_g = xfer &&
    (bus.req_last[grant_id] || at_limit);
  assign next_ptr = (grant_id == LAST_IDX) ?
    '0 : grant_id + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant_id  <= winner;
        burst_cnt <= '0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (release_g) rr_ptr <= next_ptr;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (any_req) state_nxt = LOCKED;
      LOCKED: if (release_g) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_data   =
      bus.req_data[{grant_id, 3'b000} +: 8];
    bus.tx_valid  = 1'b0;
    bus.req_ready = '0;
    busy          = 1'b0;
    if (state == LOCKED) begin
      busy                    = 1'b1;
      bus.tx_valid            = bus.req_valid[grant_id];
      bus.req_ready[grant_id] = bus.tx_ready;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester model feeds bytes,
// a monitor pops expected (id, byte) pairs on every transmitter transfer.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant_id;
  logic       busy;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQUESTERS(N),
    .MAX_BURST(MB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  beat_t        rq[$];
  exp_t         sb[$];
  logic [N-1:0] paused;
  logic [N-1:0] fire;
  logic [N-1:0] drv_v;
  logic [N-1:0] drv_l;
  logic [N-1:0] drv_seen;
  logic [8*N-1:0] drv_d;
  bit           drv_found;
  int           vectors;
  int           miscompares;

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic req(int id, logic [7:0] d, logic last);
    rq.push_back({2'(id), d, last});
  endtask

  task automatic sb_add(int id, logic [7:0] d);
    sb.push_back({2'(id), d});
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || rq.size() != 0 || busy)
           && n < 200) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL %s_drain: sb %0d rq %0d left, want 0",
               name, sb.size(), rq.size());
      sb.delete();
      rq.delete();
    end
    cycle();
  endtask

  // Monitor: every transfer must match the next expected byte.
  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset && bus.tx_valid && bus.tx_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_extra: got id %0d data %h want none",
                 grant_id, bus.tx_data);
      end else begin
        e = sb.pop_front();
        check("sb_beat", {grant_id, bus.tx_data},
              {e.id, e.data});
      end
    end
  end

  // Requester model: present the head byte of each id, pop on handshake.
  initial begin
    bus.req_data  = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    fire          = '0;
    forever begin
      @(negedge clock);
      fire = bus.req_valid & bus.req_ready;
      @(posedge clock);
      #2;
      for (int i = 0; i < N; i++) begin
        if (fire[i]) begin
          drv_found = 1'b0;
          for (int k = 0; k < rq.size(); k++) begin
            if (!drv_found && rq[k].id == 2'(i)) begin
              rq.delete(k);
              drv_found = 1'b1;
            end
          end
        end
      end
      drv_v    = '0;
      drv_l    = '0;
      drv_d    = '0;
      drv_seen = '0;
      for (int k = 0; k < rq.size(); k++) begin
        if (!drv_seen[rq[k].id]) begin
          drv_seen[rq[k].id] = 1'b1;
          if (!paused[rq[k].id]) begin
            drv_v[rq[k].id]            = 1'b1;
            drv_l[rq[k].id]            = rq[k].last;
            drv_d[rq[k].id*8 +: 8]     = rq[k].data;
          end
        end
      end
      bus.req_valid = drv_v;
      bus.req_last  = drv_l;
      bus.req_data  = drv_d;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    paused       = '0;
    bus.tx_ready = 1'b1;
    reset        = 1'b1;
    repeat (3) cycle();
    @(negedge clock);
    check("rst_state",
          {busy, bus.tx_valid, bus.req_ready, grant_id},
          8'h00);
    cycle();
    reset = 1'b0;
    cycle();

    // 1: three-byte message from requester 1
    req(1, 8'h41, 1'b0);
    req(1, 8'h42, 1'b0);
    req(1, 8'h43, 1'b1);
    sb_add(1, 8'h41);
    sb_add(1, 8'h42);
    sb_add(1, 8'h43);
    @(negedge clock);
    check("t1_arb_cycle", {busy, bus.tx_valid}, 2'b00);
    @(negedge clock);
    check("t1_byte0",
          {busy, grant_id, bus.tx_valid,
           bus.tx_data, bus.req_ready},
          {1'b1, 2'd1, 1'b1, 8'h41, 4'b0010});
    @(negedge clock);
    check("t1_byte1", bus.tx_data, 8'h42);
    @(negedge clock);
    check("t1_byte2", bus.tx_data, 8'h43);
    @(negedge clock);
    check("t1_release",
          {busy, bus.tx_valid, bus.req_ready}, 6'b0);
    wait_done("t1");

    // rr_ptr is now 2: requester 3 beats requester 1
    req(3, 8'h33, 1'b1);
    req(1, 8'h11, 1'b1);
    sb_add(3, 8'h33);
    sb_add(1, 8'h11);
    @(negedge clock);
    @(negedge clock);
    check("t1_rr_ptr", grant_id, 2'd3);
    wait_done("t1b");

    // 2: simultaneous requests from reset, 1-cycle gap between grants
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req(0, 8'hA0, 1'b1);
    req(2, 8'hA2, 1'b1);
    sb_add(0, 8'hA0);
    sb_add(2, 8'hA2);
    @(negedge clock);
    check("t2_arb_cycle", busy, 1'b0);
    @(negedge clock);
    check("t2_grant0", {busy, grant_id, bus.req_ready},
          {1'b1, 2'd0, 4'b0001});
    @(negedge clock);
    check("t2_gap", {busy, bus.tx_valid, grant_id},
          {1'b0, 1'b0, 2'd0});
    @(negedge clock);
    check("t2_grant2", {busy, grant_id, bus.req_ready},
          {1'b1, 2'd2, 4'b0100});
    wait_done("t2");

    // 3: burst limit forces release after 4 bytes
    for (int k = 0; k < 6; k++)
      req(3, 8'h30 + 8'(k), k == 5);
    req(0, 8'h0A, 1'b1);
    for (int k = 0; k < 4; k++)
      sb_add(3, 8'h30 + 8'(k));
    sb_add(0, 8'h0A);
    sb_add(3, 8'h34);
    sb_add(3, 8'h35);
    repeat (6) @(negedge clock);
    check("t3_forced_release", {busy, bus.tx_valid}, 2'b00);
    @(negedge clock);
    check("t3_req0_served", {grant_id, bus.tx_data},
          {2'd0, 8'h0A});
    wait_done("t3");

    // 4: granted requester stalls mid-message
    req(0, 8'h50, 1'b0);
    req(0, 8'h51, 1'b0);
    req(0, 8'h52, 1'b1);
    req(1, 8'h60, 1'b1);
    sb_add(0, 8'h50);
    sb_add(0, 8'h51);
    sb_add(0, 8'h52);
    sb_add(1, 8'h60);
    cycle();
    cycle();
    paused[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("t4_hold",
            {busy, grant_id, bus.tx_valid, bus.req_ready},
            {1'b1, 2'd0, 1'b0, 4'b0001});
      cycle();
    end
    paused[0] = 1'b0;
    wait_done("t4");

    // 5: transmitter stalls 20 cycles
    bus.tx_ready = 1'b0;
    req(2, 8'h77, 1'b0);
    req(2, 8'h78, 1'b1);
    sb_add(2, 8'h77);
    sb_add(2, 8'h78);
    cycle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("t5_stall",
            {busy, bus.tx_valid, bus.tx_data, bus.req_ready},
            {1'b1, 1'b1, 8'h77, 4'b0000});
      cycle();
    end
    bus.tx_ready = 1'b1;
    @(negedge clock);
    check("t5_resume", bus.req_ready, 4'b0100);
    wait_done("t5");

    // 6: reset in LOCKED after two bytes
    req(1, 8'h90, 1'b0);
    req(1, 8'h91, 1'b0);
    req(1, 8'h92, 1'b0);
    req(1, 8'h93, 1'b1);
    sb_add(1, 8'h90);
    sb_add(1, 8'h91);
    cycle();
    cycle();
    cycle();
    reset = 1'b1;
    rq.delete();
    cycle();
    @(negedge clock);
    check("t6_reset",
          {busy, bus.tx_valid, bus.req_ready, grant_id},
          8'h00);
    cycle();
    reset = 1'b0;
    req(3, 8'hC3, 1'b1);
    req(1, 8'hC1, 1'b1);
    sb_add(1, 8'hC1);
    sb_add(3, 8'hC3);
    @(negedge clock);
    @(negedge clock);
    check("t6_rr_from_0", grant_id, 2'd1);
    wait_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
